// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcodes (same values as the
// ALU's), sequencer state codes, the strobe bundle and opcode-class helpers.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDO = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STO = 4'h3;
    localparam logic [3:0] OP_PRE = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_LDM = 4'h6;
    localparam logic [3:0] OP_ADN = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_CLR = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH   = 4'd0;
    localparam state_t ST_DECODE  = 4'd1;
    localparam state_t ST_OPERAND = 4'd2;
    localparam state_t ST_MEM_RD  = 4'd3;
    localparam state_t ST_MEM_WR  = 4'd4;
    localparam state_t ST_IMM     = 4'd5;
    localparam state_t ST_WB      = 4'd6;
    localparam state_t ST_EXEC    = 4'd7;
    localparam state_t ST_HALT    = 4'd8;

    typedef struct packed {
        logic rom_en;
        logic ram_rd;
        logic ram_wr;
        logic addr_sel;
        logic pc_inc;
        logic pc_load;
        logic ir_load;
        logic addr_load;
        logic acc_load;
        logic pre_load;
        logic im_int;
        logic pc_sel;
        logic halted;
    } strobe_t;

    // Instructions that carry an operand byte after the opcode byte.
    function automatic logic is_two_byte(input logic [3:0] op);
        return op inside {OP_LDO, OP_LDA, OP_STO, OP_PRE, OP_ADD, OP_JMP};
    endfunction

    // Holes in the opcode map.
    function automatic logic is_illegal(input logic [3:0] op);
        return op inside {4'hC, 4'hD, 4'hE};
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath/memory bundle. master = sequencer side.
interface cpu_sequencer_if #(
    parameter int OPW = 4,
    parameter int DW  = 8
);
    logic [DW-1:0]  ins;
    logic           mem_rdy;
    logic           resume;
    logic [OPW-1:0] op_out;
    logic           pc_sel;
    logic           im_int;
    logic           rom_en;
    logic           ram_rd;
    logic           ram_wr;
    logic           addr_sel;
    logic           pc_inc;
    logic           pc_load;
    logic           ir_load;
    logic           addr_load;
    logic           acc_load;
    logic           pre_load;
    logic           halted;
    logic           illegal;
    logic           bus_err;
    logic [DW-1:0]  retired;

    modport master (
        input  ins, mem_rdy, resume,
        output op_out, pc_sel, im_int, rom_en, ram_rd, ram_wr, addr_sel,
               pc_inc, pc_load, ir_load, addr_load, acc_load, pre_load,
               halted, illegal, bus_err, retired
    );

    modport slave (
        output ins, mem_rdy, resume,
        input  op_out, pc_sel, im_int, rom_en, ram_rd, ram_wr, addr_sel,
               pc_inc, pc_load, ir_load, addr_load, acc_load, pre_load,
               halted, illegal, bus_err, retired
    );
endinterface

// File: rtl/cpu_seq_decode.sv
// Pure combinational map from (state, latched opcode) to the strobe vector.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    output strobe_t    st
);

    // One strobe set per state; only OPERAND, MEM_RD and WB look at the opcode.
    always_comb begin
        st = '0;
        case (state)
            ST_FETCH: begin
                st.rom_en  = 1'b1;
                st.ir_load = 1'b1;
                st.pc_inc  = 1'b1;
                st.pc_sel  = 1'b1;
            end
            ST_OPERAND: begin
                st.rom_en = 1'b1;
                if (op == OP_JMP) begin
                    st.pc_load = 1'b1;
                end else begin
                    st.addr_load = 1'b1;
                    st.pc_inc    = 1'b1;
                end
            end
            ST_MEM_RD: begin
                st.addr_sel = 1'b1;
                // LDO reads its operand from ROM space, everything else from RAM.
                if (op == OP_LDO) st.rom_en = 1'b1;
                else              st.ram_rd = 1'b1;
            end
            ST_MEM_WR: begin
                st.addr_sel = 1'b1;
                st.ram_wr   = 1'b1;
            end
            ST_IMM:  st.im_int = 1'b1;
            ST_WB: begin
                if (op == OP_PRE) st.pre_load = 1'b1;
                else              st.acc_load = 1'b1;
            end
            ST_HALT: st.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit CPU. Owns the instruction
// FSM, the memory wait counter, sticky error flags and the retire counter;
// strobes come from cpu_seq_decode.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int DW          = 8,
    parameter int RDY_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    cpu_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(RDY_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [OPW-1:0]   op_in;
    logic [WAIT_W-1:0] wait_q;
    logic [DW-1:0]    retired_q;
    logic             illegal_q, bus_err_q;
    logic             illegal_set, timeout, in_mem, retire;
    strobe_t          st, st_g;
    logic             unused_ins;

    assign op_in      = bus.ins[DW-1:DW-OPW];
    assign unused_ins = ^bus.ins[DW-OPW-1:0];
    assign in_mem     = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign timeout    = in_mem && !bus.mem_rdy &&
                        (wait_q == WAIT_W'(RDY_TIMEOUT - 1));
    // Every path back to FETCH completes (or abandons) exactly one instruction.
    assign retire     = (state_q != ST_FETCH) && (state_d == ST_FETCH);

    // Next-state and next-opcode selection.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        illegal_set = 1'b0;
        case (state_q)
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_illegal(op_in)) begin
                    illegal_set = 1'b1;
                    op_d        = OP_NOP;
                    state_d     = ST_EXEC;
                end else begin
                    op_d = op_in;
                    if (is_two_byte(op_in)) state_d = ST_OPERAND;
                    else begin
                        case (op_in)
                            OP_ADN, OP_CLR: state_d = ST_IMM;
                            OP_INC, OP_DEC: state_d = ST_WB;
                            OP_HLT:         state_d = ST_HALT;
                            OP_NOP, OP_LDM: state_d = ST_EXEC;
                            default:        state_d = ST_EXEC;
                        endcase
                    end
                end
            end
            ST_OPERAND: begin
                if (op_q == OP_JMP)      state_d = ST_FETCH;
                else if (op_q == OP_STO) state_d = ST_MEM_WR;
                else                     state_d = ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (bus.mem_rdy) state_d = ST_WB;
                else if (timeout) state_d = ST_FETCH;
            end
            ST_MEM_WR: begin
                if (bus.mem_rdy || timeout) state_d = ST_FETCH;
            end
            ST_IMM:  state_d = ST_WB;
            ST_WB:   state_d = ST_FETCH;
            ST_EXEC: state_d = ST_FETCH;
            ST_HALT: if (bus.resume) state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
        // op_out reads NOP through FETCH/DECODE of the next instruction.
        if (state_d == ST_FETCH) op_d = OP_NOP;
    end

    // FSM, wait counter, sticky flags and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            op_q      <= OP_NOP;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= (in_mem && !bus.mem_rdy && !timeout) ? wait_q + 1'b1 : '0;
            illegal_q <= illegal_q | illegal_set;
            bus_err_q <= bus_err_q | timeout;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    cpu_seq_decode u_decode (
        .state (state_q),
        .op    (op_q),
        .st    (st)
    );

    // Reset kills strobes immediately rather than waiting for the state to settle.
    assign st_g = rst ? '0 : st;

    assign bus.op_out    = op_q;
    assign bus.pc_sel    = st_g.pc_sel;
    assign bus.im_int    = st_g.im_int;
    assign bus.rom_en    = st_g.rom_en;
    assign bus.ram_rd    = st_g.ram_rd;
    assign bus.ram_wr    = st_g.ram_wr;
    assign bus.addr_sel  = st_g.addr_sel;
    assign bus.pc_inc    = st_g.pc_inc;
    assign bus.pc_load   = st_g.pc_load;
    assign bus.ir_load   = st_g.ir_load;
    assign bus.addr_load = st_g.addr_load;
    assign bus.acc_load  = st_g.acc_load;
    assign bus.pre_load  = st_g.pre_load;
    assign bus.halted    = st_g.halted;
    assign bus.illegal   = illegal_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level model pushes the expected
// per-cycle output word into a queue; a monitor pops and compares each cycle.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.OPW(4), .DW(8)) bus ();

    cpu_sequencer #(.OPW(4), .DW(8), .RDY_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Strobe bit positions inside the 13-bit expected strobe field.
    localparam logic [12:0] ROM  = 13'h1000, RRD = 13'h0800, RWR = 13'h0400,
                            ADS  = 13'h0200, PCI = 13'h0100, PCL = 13'h0080,
                            IRL  = 13'h0040, ADL = 13'h0020, ACC = 13'h0010,
                            PREL = 13'h0008, IMI = 13'h0004, PCS = 13'h0002,
                            HLTD = 13'h0001;

    logic [26:0] expq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        m_ill = 1'b0;
    logic        m_berr = 1'b0;
    logic [7:0]  m_ret = 8'h00;

    function automatic logic [26:0] dut_vec();
        return {bus.op_out, bus.rom_en, bus.ram_rd, bus.ram_wr, bus.addr_sel,
                bus.pc_inc, bus.pc_load, bus.ir_load, bus.addr_load, bus.acc_load,
                bus.pre_load, bus.im_int, bus.pc_sel, bus.halted,
                bus.illegal, bus.bus_err, bus.retired};
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    task automatic chk(input string nm, input logic [26:0] got, input logic [26:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s @%0t: got op=%h strb=%b ill=%b berr=%b ret=%0d, want op=%h strb=%b ill=%b berr=%b ret=%0d",
                      nm, $time, got[26:23], got[22:10], got[9], got[8], got[7:0],
                      want[26:23], want[22:10], want[9], want[8], want[7:0]);
    endtask

    // Monitor: compare whatever the model expected for the current cycle.
    initial begin
        logic [26:0] e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("cycle", dut_vec(), e);
            end
        end
    end

    // One clock cycle: drive inputs, record expectation, advance to next cycle.
    task automatic step(input logic [12:0] s, input logic [3:0] op, input logic [7:0] iv,
                        input logic rdy, input logic res);
        bus.ins     = iv;
        bus.mem_rdy = rdy;
        bus.resume  = res;
        expq.push_back({op, s, m_ill, m_berr, m_ret});
        @(posedge clk);
        #1;
    endtask

    // Whole instruction from the instruction-set rules. wait_n = cycles of
    // mem_rdy low before it rises (>=15 means it never does); halt_n = idle
    // HALT cycles before resume.
    task automatic run_instr(input logic [7:0] ir, input logic [7:0] opnd,
                             input int wait_n, input int halt_n);
        logic [3:0]  op;
        logic [12:0] ms;
        int          n;
        op = ir[7:4];
        step(ROM | IRL | PCI | PCS, 4'h0, ir, rnd1(), rnd1());
        step(13'h0, 4'h0, ir, rnd1(), rnd1());
        if (op inside {4'hC, 4'hD, 4'hE}) begin
            m_ill = 1'b1;
            step(13'h0, 4'h0, rnd8(), rnd1(), rnd1());
        end else if (op == 4'hF) begin
            for (int i = 0; i < halt_n; i++) step(HLTD, op, rnd8(), rnd1(), 1'b0);
            step(HLTD, op, rnd8(), rnd1(), 1'b1);
        end else if (op inside {4'h0, 4'h6}) begin
            step(13'h0, op, rnd8(), rnd1(), rnd1());
        end else if (op inside {4'h8, 4'h9}) begin
            step(ACC, op, rnd8(), rnd1(), rnd1());
        end else if (op inside {4'h7, 4'hB}) begin
            step(IMI, op, rnd8(), rnd1(), rnd1());
            step(ACC, op, rnd8(), rnd1(), rnd1());
        end else if (op == 4'hA) begin
            step(ROM | PCL, op, opnd, rnd1(), rnd1());
        end else begin
            step(ROM | ADL | PCI, op, opnd, rnd1(), rnd1());
            ms = ADS | ((op == 4'h3) ? RWR : (op == 4'h1) ? ROM : RRD);
            n  = (wait_n < 15) ? wait_n : 15;
            for (int i = 0; i < n; i++) step(ms, op, rnd8(), 1'b0, rnd1());
            if (wait_n >= 15) m_berr = 1'b1;
            else begin
                step(ms, op, rnd8(), 1'b1, rnd1());
                if (op != 4'h3) step((op == 4'h4) ? PREL : ACC, op, rnd8(), rnd1(), rnd1());
            end
        end
        m_ret = m_ret + 8'd1;
    endtask

    initial begin
        logic [7:0] ir, opnd;
        int         w;
        bus.ins = 8'h00; bus.mem_rdy = 1'b0; bus.resume = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), 27'h0);
        rst = 1'b0;

        // Directed sequence
        run_instr(8'h80, 8'h00, 0, 0);          // INC
        run_instr(8'h73, 8'h00, 0, 0);          // ADN 3
        run_instr(8'h20, 8'h1C, 3, 0);          // LDA 0x1C, 3 wait cycles
        run_instr(8'h30, 8'h55, 20, 0);         // STO, mem_rdy stuck low
        run_instr(8'h90, 8'h00, 0, 0);          // DEC, bus_err still set
        run_instr(8'hA0, 8'h40, 0, 0);          // JMP 0x40
        run_instr(8'hF0, 8'h00, 6, 6);          // HLT, resume after 6 cycles
        run_instr(8'hD0, 8'h00, 0, 0);          // illegal
        run_instr(8'h40, 8'h10, 1, 0);          // PRE
        run_instr(8'h10, 8'h22, 0, 0);          // LDO

        // Reset asserted mid-MEM_WR
        step(ROM | IRL | PCI | PCS, 4'h0, 8'h35, 1'b1, 1'b0);
        step(13'h0, 4'h0, 8'h35, 1'b1, 1'b0);
        step(ROM | ADL | PCI, 4'h3, 8'h90, 1'b1, 1'b0);
        step(ADS | RWR, 4'h3, 8'h00, 1'b0, 1'b0);
        bus.mem_rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_mid_wr", dut_vec(), 27'h0);
        @(posedge clk);
        #1;
        chk("reset_held", dut_vec(), 27'h0);
        m_ill = 1'b0; m_berr = 1'b0; m_ret = 8'h00;
        rst = 1'b0;

        // Random instruction stream (enough to wrap the retire counter)
        for (int k = 0; k < 300; k++) begin
            ir   = rnd8();
            opnd = rnd8();
            w    = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            run_instr(ir, opnd, w, int'($urandom_range(0, 4)));
        end

        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish before 2000000");
        $fatal(1, "watchdog");
    end

endmodule
